// File: rtl/uart_mmio_pkg.sv
// Shared constants for the UART bus front end: register map, STATUS/CTRL bit
// positions and the transmit launcher state encoding.
package uart_mmio_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_RX_NEMPTY = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_TX_BUSY   = 3;
    localparam int ST_RXOVR     = 4;
    localparam int ST_TXOVF     = 5;
    localparam int ST_LAUNCH    = 6;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_RXIE  = 1;
    localparam int CTRL_TXIE  = 2;

    typedef enum logic {
        L_IDLE = 1'b0,
        L_WAIT = 1'b1
    } launch_state_e;

endpackage

// File: rtl/uart_mmio_fifo.sv
// Small synchronous FIFO with flush; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, a pop from an empty FIFO is ignored.
module uart_mmio_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// Register-bus front end for the byte UART: TX/RX FIFOs, sticky overflow flags,
// interrupt generation and the launcher that hands queued bytes to the core.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  ADDR,
    input  logic        WE,
    input  logic        RE,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        IRQ,
    output logic [7:0]  U_TXDATA,
    output logic        U_TXSTART,
    input  logic        U_TXBUSY,
    input  logic        U_TXDONE,
    input  logic [7:0]  U_RXDATA,
    input  logic        U_RXDONE
);

    logic [1:0]    reg_idx;
    logic          rd_en;
    logic          wr_data, wr_status, wr_ctrl, rd_data;
    logic          flush, launch;
    logic          tx_full, tx_empty, rx_full, rx_empty, rx_pop;
    logic [7:0]    tx_head, rx_head;
    logic [31:0]   status;
    logic [31:0]   rdata_q, rdata_d;
    logic          rxovr_q, rxovr_d;
    logic          txovf_q, txovf_d;
    logic          rxie_q, rxie_d;
    logic          txie_q, txie_d;
    launch_state_e state_q;
    logic          txstart_q;
    logic [7:0]    txdata_q;
    logic          unused_bits;

    assign unused_bits = ^{ADDR[1:0], WDATA[31:8]};

    assign reg_idx   = ADDR[3:2];
    assign rd_en     = RE & ~WE;
    assign wr_data   = WE & (reg_idx == REG_DATA);
    assign wr_status = WE & (reg_idx == REG_STATUS);
    assign wr_ctrl   = WE & (reg_idx == REG_CTRL);
    assign rd_data   = rd_en & (reg_idx == REG_DATA);
    assign flush     = wr_ctrl & WDATA[CTRL_FLUSH];
    assign rx_pop    = rd_data & ~rx_empty;
    assign launch    = (state_q == L_IDLE) & ~tx_empty & ~U_TXBUSY;

    uart_mmio_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (wr_data),
        .pop   (launch),
        .flush (flush),
        .din   (WDATA[7:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_mmio_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (U_RXDONE),
        .pop   (rx_pop),
        .flush (flush),
        .din   (U_RXDATA),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        status               = '0;
        status[ST_RX_NEMPTY] = ~rx_empty;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_BUSY]   = U_TXBUSY;
        status[ST_RXOVR]     = rxovr_q;
        status[ST_TXOVF]     = txovf_q;
        status[ST_LAUNCH]    = (state_q != L_IDLE);
    end

    // Sticky flags clear on write-1 but a same-cycle overflow must still win.
    always_comb begin
        rxovr_d = rxovr_q;
        txovf_d = txovf_q;
        rxie_d  = rxie_q;
        txie_d  = txie_q;
        if (wr_status && WDATA[ST_RXOVR]) rxovr_d = 1'b0;
        if (wr_status && WDATA[ST_TXOVF]) txovf_d = 1'b0;
        if (U_RXDONE && rx_full && !rx_pop) rxovr_d = 1'b1;
        if (wr_data && tx_full && !launch) txovf_d = 1'b1;
        if (wr_ctrl) begin
            rxie_d = WDATA[CTRL_RXIE];
            txie_d = WDATA[CTRL_TXIE];
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (reg_idx)
                REG_DATA:   rdata_d = rx_empty ? 32'd0 : {24'd0, rx_head};
                REG_STATUS: rdata_d = status;
                REG_CTRL:   rdata_d = {29'd0, txie_q, rxie_q, 1'b0};
                REG_RSVD:   rdata_d = 32'd0;
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rdata_q <= '0;
            rxovr_q <= 1'b0;
            txovf_q <= 1'b0;
            rxie_q  <= 1'b0;
            txie_q  <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            rxovr_q <= rxovr_d;
            txovf_q <= txovf_d;
            rxie_q  <= rxie_d;
            txie_q  <= txie_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= L_IDLE;
            txstart_q <= 1'b0;
            txdata_q  <= '0;
        end else begin
            txstart_q <= 1'b0;
            case (state_q)
                L_IDLE: begin
                    if (launch) begin
                        state_q   <= L_WAIT;
                        txstart_q <= 1'b1;
                        txdata_q  <= tx_head;
                    end
                end
                L_WAIT: begin
                    if (U_TXDONE) state_q <= L_IDLE;
                end
                default: state_q <= L_IDLE;
            endcase
        end
    end

    assign RDATA     = rdata_q;
    assign U_TXSTART = txstart_q;
    assign U_TXDATA  = txdata_q;
    assign IRQ       = (rxie_q & ~rx_empty) | (txie_q & tx_empty & (state_q == L_IDLE));

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped bus front end for the byte-level UART core: a CPU writes bytes into a TX FIFO and reads received bytes from an RX FIFO through a simple single-cycle register bus. The block drives the core's transmit-request side (data, start pulse) and consumes its receive-completion side (data, done pulse). It sits between the system bus decoder and the UART, adding buffering, sticky error flags and an interrupt line.

## Interface
- DEPTH, 4: entries per FIFO; power of two, ≥2.
- CLK  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-low.
- ADDR  in  4  byte address; ADDR[3:2] selects register, ADDR[1:0] ignored.
- WE  in  1  write strobe, one transfer per cycle.
- RE  in  1  read strobe; WE and RE never both high (WE wins if they are).
- WDATA  in  32  write data.
- RDATA  out  32  read data, registered, valid cycle after RE.
- IRQ  out  1  level interrupt.
- U_TXDATA  out  8  byte to UART transmitter.
- U_TXSTART  out  1  one-cycle transmit request.
- U_TXBUSY  in  1  transmitter busy.
- U_TXDONE  in  1  one-cycle transmit-complete pulse.
- U_RXDATA  in  8  received byte, valid while U_RXDONE high.
- U_RXDONE  in  1  one-cycle receive-complete pulse.

## Operation
- Registers (ADDR[3:2]): 0 DATA, 1 STATUS, 2 CTRL, 3 reserved (reads 0, writes ignored).
- DATA write: push WDATA[7:0] to TX FIFO; if full (and no same-cycle pop) drop byte, set TXOVF.
- DATA read: pop RX FIFO, RDATA = {24'b0, head}; if empty, RDATA = 0, no pop, no flag.
- STATUS read: bit0 RX nonempty, bit1 TX full, bit2 TX empty, bit3 U_TXBUSY, bit4 RXOVR, bit5 TXOVF, bit6 launcher not IDLE; others 0.
- STATUS write: bits 4/5 write-1-to-clear; other bits ignored. Set and clear in same cycle: set wins.
- CTRL write: bit0 FLUSH (self-clearing, empties both FIFOs), bit1 RXIE, bit2 TXIE. CTRL read: {29'b0, TXIE, RXIE, 1'b0}.
- RX path: on U_RXDONE push U_RXDATA; if full and no same-cycle DATA-read pop, drop byte, set RXOVR.
- TX launcher FSM:
  - IDLE: TX FIFO nonempty and U_TXBUSY low -> drive U_TXDATA = head, U_TXSTART = 1 for one cycle, pop, go WAIT.
  - WAIT: on U_TXDONE -> IDLE.
- U_TXDATA holds last launched byte until next launch.
- IRQ = (RXIE & RX nonempty) | (TXIE & TX empty & FSM IDLE).
- Simultaneous push+pop on any FIFO: both occur, count unchanged, legal even when full or (pop ignored) empty.
- FLUSH with push in same cycle: FLUSH wins, FIFO empty. FLUSH during WAIT: in-flight byte completes, FSM unaffected.
- Pointers are log2(DEPTH) bits wrapping naturally; count is log2(DEPTH)+1 bits.

## Timing
- Reset values: RDATA 0, IRQ 0, U_TXDATA 0, U_TXSTART 0; FIFOs empty, flags/RXIE/TXIE 0, FSM IDLE.
- Reset mid-transfer: all state cleared immediately; no further U_TXSTART until a new byte is written.
- Read latency 1 cycle; register write effects visible to STATUS read issued next cycle.
- DATA write into empty TX FIFO with idle UART: U_TXSTART high 2 cycles after WE cycle (push at edge 1, launch at edge 2).
- Back-to-back bytes: next U_TXSTART no earlier than 1 cycle after U_TXDONE.
- U_RXDONE to STATUS bit0 set: 1 cycle.

## Structure
- Package uart_mmio_pkg: register index constants (DATA/STATUS/CTRL), STATUS and CTRL bit positions, launcher state encoding (IDLE, WAIT).
- Sub-module uart_mmio_fifo (parameter DEPTH, WIDTH=8; push, pop, flush, data in/out, full, empty), instantiated twice.
- Launcher FSM, register decode and flags in top level.

## Test plan
- Reset then write 0x55, 0xA3 to DATA -> U_TXSTART pulses with U_TXDATA 0x55 then 0xA3, second only after U_TXDONE; STATUS bit2 returns to 1.
- Hold U_TXBUSY high, write DEPTH+1 bytes -> STATUS bit1=1, bit5=1; write 0x20 to STATUS -> bit5=0, bit1 still 1.
- Pulse U_RXDONE with 0x31, 0x32 -> two DATA reads return 0x31, 0x32, third returns 0; STATUS bit0 goes 1 then 0.
- Fill RX FIFO, pulse U_RXDONE with 0x99 -> RXOVR set, byte dropped; repeat with concurrent DATA read -> byte accepted, no RXOVR.
- CTRL=0x6 with RX FIFO empty, TX idle -> IRQ=1 (TX empty); CTRL=0x2 -> IRQ=0 until U_RXDONE, then 1 until drained.
- Assert RESET during WAIT with 2 bytes queued -> outputs at reset values, no U_TXSTART after release.
